cmos_dvp_pattern_gen: RTL and testbench



---
 rtl/cmos_dvp_pattern_gen.sv | 193 +++++++++++++++++++
 tb/tb_cmos_dvp_pattern_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_dvp_pattern_gen.sv
// Synthetic OV5640-style DVP byte source: frames of RGB565 test patterns, high byte first.
// All outputs are registered from the next-state decode so href/vsync/data align with state changes.
module cmos_dvp_pattern_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int H_BLANK  = 64,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST   = 16'(LINE_LEN - 1);
  localparam logic [15:0] ACT_LAST = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] VS_LAST  = 16'(VS_LINES - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] SEG_LAST = 16'(H_ACTIVE / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_LINE_ACT, S_LINE_BLK, S_VFRONT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] hcnt, hcnt_nx, lcnt, lcnt_nx;
  logic [15:0] x, x_nx, y, y_nx, seg, seg_nx;
  logic [2:0]  bar, bar_nx;
  logic        phase, phase_nx;
  logic [1:0]  psel, psel_nx;
  logic        frame_done, start_frame, start_act;
  logic [15:0] pix_nx;
  logic [7:0]  byte_nx;

  always_comb begin
    state_nx    = state;
    hcnt_nx     = hcnt;
    lcnt_nx     = lcnt;
    x_nx        = x;
    y_nx        = y;
    seg_nx      = seg;
    bar_nx      = bar;
    phase_nx    = phase;
    psel_nx     = psel;
    frame_done  = 1'b0;
    start_frame = 1'b0;
    start_act   = 1'b0;
    case (state)
      S_IDLE: if (en) start_frame = 1'b1;
      S_VSYNC: begin
        if (hcnt == H_LAST) begin
          hcnt_nx = '0;
          if (lcnt == VS_LAST) begin
            lcnt_nx = '0;
            if (V_BACK == 0) start_act = 1'b1;
            else             state_nx  = S_VBACK;
          end else lcnt_nx = lcnt + 16'd1;
        end else hcnt_nx = hcnt + 16'd1;
      end
      S_VBACK: begin
        if (hcnt == H_LAST) begin
          hcnt_nx = '0;
          if (lcnt == VB_LAST) begin
            lcnt_nx   = '0;
            start_act = 1'b1;
          end else lcnt_nx = lcnt + 16'd1;
        end else hcnt_nx = hcnt + 16'd1;
      end
      S_LINE_ACT: begin
        hcnt_nx  = hcnt + 16'd1;
        phase_nx = ~phase;
        // Pixel position advances after its low byte; the bar segment counter replaces x/(H_ACTIVE/8).
        if (phase) begin
          x_nx = x + 16'd1;
          if (seg == SEG_LAST) begin
            seg_nx = '0;
            bar_nx = bar + 3'd1;
          end else seg_nx = seg + 16'd1;
        end
        if (hcnt == ACT_LAST) state_nx = S_LINE_BLK;
      end
      S_LINE_BLK: begin
        if (hcnt == H_LAST) begin
          hcnt_nx = '0;
          if (y == Y_LAST) begin
            lcnt_nx = '0;
            if (V_FRONT == 0) frame_done = 1'b1;
            else              state_nx   = S_VFRONT;
          end else begin
            y_nx      = y + 16'd1;
            start_act = 1'b1;
          end
        end else hcnt_nx = hcnt + 16'd1;
      end
      S_VFRONT: begin
        if (hcnt == H_LAST) begin
          hcnt_nx = '0;
          if (lcnt == VF_LAST) begin
            lcnt_nx    = '0;
            frame_done = 1'b1;
          end else lcnt_nx = lcnt + 16'd1;
        end else hcnt_nx = hcnt + 16'd1;
      end
      default: state_nx = S_IDLE;
    endcase
    if (frame_done) begin
      if (en) start_frame = 1'b1;
      else    state_nx    = S_IDLE;
    end
    if (start_frame) begin
      state_nx = S_VSYNC;
      psel_nx  = pattern_sel;
      hcnt_nx  = '0;
      lcnt_nx  = '0;
      y_nx     = '0;
    end
    if (start_act) begin
      state_nx = S_LINE_ACT;
      x_nx     = '0;
      seg_nx   = '0;
      bar_nx   = '0;
      phase_nx = 1'b0;
    end
  end

  always_comb begin
    pix_nx = 16'h0000;
    case (psel_nx)
      2'd0: begin
        case (bar_nx)
          3'd0:    pix_nx = 16'hFFFF;
          3'd1:    pix_nx = 16'hFFE0;
          3'd2:    pix_nx = 16'h07FF;
          3'd3:    pix_nx = 16'h07E0;
          3'd4:    pix_nx = 16'hF81F;
          3'd5:    pix_nx = 16'hF800;
          3'd6:    pix_nx = 16'h001F;
          default: pix_nx = 16'h0000;
        endcase
      end
      2'd1:    pix_nx = x_nx;
      2'd2:    pix_nx = (x_nx[5] ^ y_nx[5]) ? 16'hFFFF : 16'h0000;
      default: pix_nx = {y_nx[7:0], x_nx[7:0]};
    endcase
    byte_nx = 8'h00;
    if (state_nx == S_LINE_ACT) byte_nx = phase_nx ? pix_nx[7:0] : pix_nx[15:8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      lcnt      <= '0;
      x         <= '0;
      y         <= '0;
      seg       <= '0;
      bar       <= '0;
      phase     <= 1'b0;
      psel      <= '0;
      frame_cnt <= '0;
      cam_vsync <= 1'b0;
      cam_href  <= 1'b0;
      cam_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      hcnt      <= hcnt_nx;
      lcnt      <= lcnt_nx;
      x         <= x_nx;
      y         <= y_nx;
      seg       <= seg_nx;
      bar       <= bar_nx;
      phase     <= phase_nx;
      psel      <= psel_nx;
      frame_cnt <= frame_cnt + 16'(frame_done);
      cam_vsync <= (state_nx == S_VSYNC);
      cam_href  <= (state_nx == S_LINE_ACT);
      cam_data  <= byte_nx;
      busy      <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cmos_dvp_pattern_gen.sv
// Bench for cmos_dvp_pattern_gen: a frame-timeline model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_cmos_dvp_pattern_gen;

  localparam int HA = 16, VA = 4, HB = 8, VS = 2, VB = 1, VF = 1;
  localparam int LL = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LL;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [1:0]  pattern_sel;
  logic        cam_vsync, cam_href, busy;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;

  int vectors = 0, miscompares = 0, fail_prints = 0;

  cmos_dvp_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (fail_prints < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      fail_prints++;
    end
  endtask

  // Model: a frame is a timeline t = 0..FRAME-1 counted from the first vsync cycle.
  bit         m_valid = 0, m_run = 0;
  int         m_t = 0;
  logic [1:0] m_psel = 0;
  logic [15:0] m_fc = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_run = 0; m_t = 0; m_fc = 0;
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_t = 0; m_psel = pattern_sel; end
    end else if (m_t == FRAME - 1) begin
      m_fc = m_fc + 16'd1;
      if (en) begin m_t = 0; m_psel = pattern_sel; end
      else m_run = 0;
    end else m_t++;
  end

  function automatic logic [15:0] pix(input logic [1:0] p, input int px, input int py);
    case (p)
      2'd0: begin
        case (px / (HA / 8))
          0: return 16'hFFFF; 1: return 16'hFFE0; 2: return 16'h07FF; 3: return 16'h07E0;
          4: return 16'hF81F; 5: return 16'hF800; 6: return 16'h001F; default: return 16'h0000;
        endcase
      end
      2'd1:    return 16'(px);
      2'd2:    return ((((px >> 5) ^ (py >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return 16'((py % 256) * 256 + (px % 256));
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      int a, ln, c;
      logic e_vs, e_href;
      logic [7:0] e_data;
      logic [15:0] p;
      e_vs = m_run && (m_t < VS * LL);
      a = m_t - (VS + VB) * LL;
      e_href = 0;
      e_data = 8'h00;
      if (m_run && a >= 0 && a < VA * LL) begin
        ln = a / LL;
        c  = a % LL;
        if (c < 2 * HA) begin
          e_href = 1;
          p = pix(m_psel, c / 2, ln);
          e_data = (c % 2 == 0) ? p[15:8] : p[7:0];
        end
      end
      check("model_vsync", int'(cam_vsync), int'(e_vs));
      check("model_href", int'(cam_href), int'(e_href));
      check("model_data", int'(cam_data), int'(e_data));
      check("model_busy", int'(busy), int'(m_run));
      check("model_frame_cnt", int'(frame_cnt), int'(m_fc));
    end
  end

  function automatic logic sig(input int s);
    return (s == 0) ? cam_vsync : cam_href;
  endfunction

  // Waits (bounded) for a rising edge of vsync (s=0) or href (s=1), returning on the first high sample.
  task automatic wait_rise(input int s, input string nm);
    int n = 0;
    logic prev;
    prev = sig(s);
    @(negedge clk);
    while (!(!prev && sig(s)) && n < 2000) begin
      prev = sig(s);
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({"timeout_", nm}, 0, 1);
  endtask

  logic [255:0] bar_bytes;
  logic [7:0]   exp_q[$];
  logic [7:0]   e;
  realtime      t1;
  int           n, lines, fc0, bad, hb, nz;
  logic         prev_h;

  initial begin
    rst_n = 1'b0; en = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_vsync", int'(cam_vsync), 0);
    check("reset_href", int'(cam_href), 0);
    check("reset_data", int'(cam_data), 0);
    check("reset_frame_cnt", int'(frame_cnt), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1; en = 1'b1;

    // Frame 1, colour bars: vsync / back-porch / line timing and line-0 bytes.
    wait_rise(0, "vs1");
    t1 = $realtime;
    n = 0;
    while (cam_vsync && n < 1000) begin n++; @(negedge clk); end
    check("vsync_high_cycles", n, 80);
    n = 0;
    while (!cam_href && n < 1000) begin n++; @(negedge clk); end
    check("vback_quiet_cycles", n, 40);
    bar_bytes = 256'hFFFFFFFFFFE0FFE007FF07FF07E007E0F81FF81FF800F800001F001F00000000;
    for (int i = 0; i < 32; i++) exp_q.push_back(bar_bytes[255 - 8 * i -: 8]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bars_line0_byte", int'(cam_data), int'(e));
      @(negedge clk);
    end
    n = 0;
    while (!cam_href && n < 1000) begin n++; @(negedge clk); end
    check("hblank_cycles", n, 8);
    n = 0;
    while (cam_href && n < 1000) begin n++; @(negedge clk); end
    check("href_high_cycles", n, 32);
    wait_rise(0, "vs2");
    check("frame_period", int'(($realtime - t1) / 10.0), 320);
    check("frame_cnt_after_1", int'(frame_cnt), 1);

    // Coordinate pattern takes effect from the next frame boundary.
    pattern_sel = 2'd3;
    wait_rise(0, "vs3");
    repeat (3) wait_rise(1, "line_c");
    repeat (10) @(negedge clk);
    check("coord_x5y2_hi", int'(cam_data), 8'h02);
    @(negedge clk);
    check("coord_x5y2_lo", int'(cam_data), 8'h05);

    // en dropped during line 1: the frame finishes, then the generator idles.
    wait_rise(0, "vs4");
    lines = 0;
    repeat (2) begin wait_rise(1, "line_en"); lines++; end
    repeat (5) @(negedge clk);
    en = 1'b0;
    fc0 = int'(frame_cnt);
    check("frame_cnt_before_drop", fc0, 3);
    n = 0;
    prev_h = cam_href;
    while (busy && n < 1000) begin
      @(negedge clk);
      if (!prev_h && cam_href) lines++;
      prev_h = cam_href;
      n++;
    end
    check("busy_fell", int'(busy), 0);
    check("lines_after_en_drop", lines, 4);
    check("frame_cnt_after_drop", int'(frame_cnt), fc0 + 1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (cam_vsync || cam_href || cam_data != 8'h00 || busy) bad++;
    end
    check("idle_quiet_cycles_bad", bad, 0);

    // Ramp frame with pattern_sel changed to checker mid-frame.
    pattern_sel = 2'd1; en = 1'b1;
    wait_rise(0, "vs5");
    @(negedge clk);
    pattern_sel = 2'd2;
    wait_rise(1, "line_r");
    repeat (6) @(negedge clk);
    check("ramp_x3_hi", int'(cam_data), 8'h00);
    @(negedge clk);
    check("ramp_x3_lo", int'(cam_data), 8'h03);
    wait_rise(0, "vs6");
    hb = 0; nz = 0;
    repeat (FRAME) begin
      if (cam_href) begin hb++; if (cam_data != 8'h00) nz++; end
      @(negedge clk);
    end
    check("checker_href_bytes", hb, 2 * HA * VA);
    check("checker_nonzero_bytes", nz, 0);

    // One-cycle reset during line 2, then restart from IDLE with en held.
    repeat (3) wait_rise(1, "line_rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_vsync", int'(cam_vsync), 0);
    check("midreset_href", int'(cam_href), 0);
    check("midreset_data", int'(cam_data), 0);
    check("midreset_frame_cnt", int'(frame_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_vsync", int'(cam_vsync), 1);
    check("restart_busy", int'(busy), 1);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
